// File: rtl/sa_act_sequencer_if.sv
// Command encoding shared by the activation sequencer and its consumers, plus the
// stream interface between the upstream activation source, the sequencer and the skew buffer.
package sa_act_pkg;
  typedef enum logic [1:0] {
    CMD_NOP    = 2'd0,
    CMD_QUEUE  = 2'd1,
    CMD_STREAM = 2'd2
  } command_t;
endpackage

// Handshake: a beat transfers on every rising clk edge where in_valid && in_ready are both high.
// The source holds in_data stable while in_valid is high and unaccepted.
// in_ready never depends on in_valid. The skew-buffer side (act_out/act_row_idx/cmd) has no
// back-pressure; an element is present whenever cmd != CMD_NOP.
interface sa_act_sequencer_if
  import sa_act_pkg::*;
#(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 32
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ACTIVATION_SIZE-1:0] in_data;
  logic [ACTIVATION_SIZE-1:0] act_out;
  logic [$clog2(SA_SIZE)-1:0] act_row_idx;
  command_t                   cmd;

  modport master (
    output in_valid, in_data,
    input  in_ready, act_out, act_row_idx, cmd
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, act_out, act_row_idx, cmd
  );
endinterface

// File: rtl/sa_act_sequencer.sv
// Turns a row-major activation stream into per-row skew-buffer writes and appends
// SA_SIZE-1 zero vectors per tile so the skewed wavefront drains out of the array.
module sa_act_sequencer
  import sa_act_pkg::*;
#(
  parameter int SA_SIZE         = 8,
  parameter int ACTIVATION_SIZE = 32,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             stall,
  sa_act_sequencer_if.slave sif,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);
  localparam int ROW_W = $clog2(SA_SIZE);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SA_SIZE - 1);
  localparam logic [CNT_W-1:0] LAST_ZERO_VEC = CNT_W'(SA_SIZE - 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [ROW_W-1:0]           row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]           vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]           k_q, k_d;
  logic [ACTIVATION_SIZE-1:0] act_out_q, act_out_d;
  logic [ROW_W-1:0]           row_idx_q, row_idx_d;
  command_t                   cmd_q, cmd_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       in_ready;
  logic                       emit;
  logic [ACTIVATION_SIZE-1:0] emit_data;
  logic                       last_row;

  // Gated by resetn so no beat is taken in a reset cycle; such a beat stays with the source.
  assign in_ready = resetn && (state_q == ST_LOAD) && !stall;
  assign last_row = (row_cnt_q == LAST_ROW);

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    vec_cnt_d = vec_cnt_q;
    k_d       = k_q;
    act_out_d = act_out_q;
    row_idx_d = row_idx_q;
    cmd_d     = CMD_NOP;
    done_d    = (state_q == ST_DONE);
    emit      = 1'b0;
    emit_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d       = num_vectors;
          row_cnt_d = '0;
          vec_cnt_d = '0;
          state_d   = (num_vectors == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (sif.in_valid && in_ready) begin
          emit      = 1'b1;
          emit_data = sif.in_data;
          if (last_row) begin
            if (vec_cnt_q == k_q - CNT_W'(1)) begin
              state_d   = ST_FLUSH;
              vec_cnt_d = '0;
            end else begin
              vec_cnt_d = vec_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_FLUSH: begin
        if (!stall) begin
          emit = 1'b1;
          if (last_row) begin
            if (vec_cnt_q == LAST_ZERO_VEC) begin
              state_d   = ST_DONE;
              vec_cnt_d = '0;
            end else begin
              vec_cnt_d = vec_cnt_q + CNT_W'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Only the last row of a vector pushes the column into the array.
    if (emit) begin
      act_out_d = emit_data;
      row_idx_d = row_cnt_q;
      cmd_d     = last_row ? CMD_STREAM : CMD_QUEUE;
      row_cnt_d = row_cnt_q + ROW_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      row_cnt_q <= '0;
      vec_cnt_q <= '0;
      k_q       <= '0;
      act_out_q <= '0;
      row_idx_q <= '0;
      cmd_q     <= CMD_NOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      vec_cnt_q <= vec_cnt_d;
      k_q       <= k_d;
      act_out_q <= act_out_d;
      row_idx_q <= row_idx_d;
      cmd_q     <= cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sif.in_ready    = in_ready;
  assign sif.act_out     = act_out_q;
  assign sif.act_row_idx = row_idx_q;
  assign sif.cmd         = cmd_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_sa_act_sequencer.sv
// Directed bench for sa_act_sequencer at SA_SIZE=4: expected elements are queued when a
// tile is issued and popped by a monitor whenever the sequencer emits a command.
module tb_sa_act_sequencer;
  import sa_act_pkg::*;

  localparam int S  = 4;
  localparam int W  = 32;
  localparam int CW = 16;
  localparam int EW = 2 + 2 + W;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic [CW-1:0] num_vectors = '0;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  sa_act_sequencer_if #(.SA_SIZE(S), .ACTIVATION_SIZE(W)) sif ();

  sa_act_sequencer #(.SA_SIZE(S), .ACTIVATION_SIZE(W), .CNT_W(CW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .num_vectors(num_vectors),
    .stall      (stall),
    .sif        (sif),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  logic [W-1:0]  tag;
  int n_vec = 0, n_fail = 0;
  int stream_cnt = 0, done_cnt = 0, done_cyc = 0, first_cyc = -1, start_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] elem(input int r, input logic [W-1:0] d);
    logic [1:0] c;
    c = (r == S - 1) ? 2'(CMD_STREAM) : 2'(CMD_QUEUE);
    return {c, 2'(r), d};
  endfunction

  // monitor
  always @(negedge clk) begin
    if (sif.cmd !== CMD_NOP) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_elem: got cmd=%0d row=%0d data=%0h, required no element",
                 sif.cmd, sif.act_row_idx, sif.act_out);
      end else begin
        exp_e = exp_q.pop_front();
        check("elem", 64'({sif.cmd, sif.act_row_idx, sif.act_out}), 64'(exp_e));
      end
      if (sif.cmd === CMD_STREAM) stream_cnt++;
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tile(input int k);
    for (int b = 0; b < k * S; b++) exp_q.push_back(elem(b % S, tag + W'(b)));
    for (int z = 0; z < (S - 1) * S; z++) exp_q.push_back(elem(z % S, '0));
  endtask

  task automatic start_tile(input int k);
    num_vectors = CW'(k);
    start       = 1'b1;
    start_cyc   = cyc;
    first_cyc   = -1;
    stream_cnt  = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic stall_window();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      @(negedge clk);
      check("stall_in_ready", 64'(sif.in_ready), 64'(0));
      if (i > 0) check("stall_nop", 64'(sif.cmd), 64'(CMD_NOP));
      tick();
    end
    stall = 1'b0;
  endtask

  task automatic send_beats(input int nb, input bit gap, input int stall_beat);
    bit chk_nop;
    chk_nop = 1'b0;
    for (int b = 0; b < nb; b++) begin
      bit fire;
      int n;
      fire = 1'b0;
      n    = 0;
      sif.in_valid = 1'b1;
      sif.in_data  = tag + W'(b);
      if (b == stall_beat) begin
        stall_window();
        chk_nop = 1'b1;
      end
      while (!fire && n < 100) begin
        @(negedge clk);
        if (chk_nop) begin
          check("nop_after_gap_or_stall", 64'(sif.cmd), 64'(CMD_NOP));
          chk_nop = 1'b0;
        end
        fire = sif.in_ready;
        n++;
        tick();
      end
      if (!fire) begin
        n_vec++;
        n_fail++;
        $display("FAIL beat_timeout: beat %0d not accepted, required acceptance", b);
      end
      sif.in_valid = 1'b0;
      if (gap) begin
        tick();
        chk_nop = 1'b1;
      end
    end
  endtask

  task automatic wait_done(input int limit);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt == d0) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done pulse", limit);
    end
  endtask

  task automatic end_tile(input int k);
    wait_done(400);
    check("stream_count", 64'(stream_cnt), 64'(k + S - 1));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic check_reset_outs(input string name);
    check(name, 64'({sif.cmd, sif.act_row_idx, sif.act_out, busy, done, sif.in_ready, dbg_state}), 64'(0));
  endtask

  initial begin
    int d0;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;

    // reset held with start and in_valid asserted
    start        = 1'b1;
    sif.in_valid = 1'b1;
    num_vectors  = CW'(5);
    repeat (3) begin
      @(negedge clk);
      check_reset_outs("reset_outs");
    end
    start        = 1'b0;
    sif.in_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();

    // K=1, data 1..4 back-to-back: latency and done timing
    tag = 32'd1;
    expect_tile(1);
    start_tile(1);
    send_beats(4, 1'b0, -1);
    end_tile(1);
    check("first_elem_latency", 64'(first_cyc - start_cyc), 64'(2));
    check("done_latency", 64'(done_cyc - start_cyc), 64'(18));

    // K=2 with in_valid toggling
    tag = 32'h100;
    expect_tile(2);
    start_tile(2);
    send_beats(8, 1'b1, -1);
    end_tile(2);

    // K=2 with a stall mid-vector in LOAD and again in FLUSH
    tag = 32'h200;
    expect_tile(2);
    start_tile(2);
    send_beats(8, 1'b0, 5);
    tick();
    tick();
    stall_window();
    @(negedge clk);
    check("nop_after_flush_stall", 64'(sif.cmd), 64'(CMD_NOP));
    tick();
    end_tile(2);

    // K=0: one busy cycle, done, no commands
    stream_cnt = 0;
    start_tile(0);
    @(negedge clk);
    check("k0_busy_done", 64'({busy, done, dbg_state}), 64'({1'b1, 1'b0, 2'd3}));
    tick();
    @(negedge clk);
    check("k0_done_pulse", 64'({busy, done}), 64'({1'b0, 1'b1}));
    tick();
    @(negedge clk);
    check("k0_done_low", 64'(done), 64'(0));
    check("k0_no_streams", 64'(stream_cnt), 64'(0));
    tick();

    // K=3 with a second start mid-tile
    tag = 32'h300;
    expect_tile(3);
    start_tile(3);
    fork
      send_beats(12, 1'b0, -1);
      begin
        repeat (5) tick();
        num_vectors = CW'(1);
        start       = 1'b1;
        tick();
        start = 1'b0;
      end
    join
    end_tile(3);

    // reset pulse at row 2 of vector 1, then a fresh tile
    tag = 32'h400;
    for (int b = 0; b < 6; b++) exp_q.push_back(elem(b % S, tag + W'(b)));
    start_tile(2);
    send_beats(6, 1'b0, -1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outs("abort_reset_outs");
    check("abort_queue", 64'(exp_q.size()), 64'(0));
    d0 = done_cnt;
    tick();
    repeat (20) tick();
    check("abort_no_done", 64'(done_cnt), 64'(d0));

    tag = 32'h500;
    expect_tile(1);
    start_tile(1);
    send_beats(4, 1'b0, -1);
    end_tile(1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/sa_act_sequencer.md
# sa_act_sequencer

Sequences activations into the input skew buffer of the TicSAT systolic array. Accepts a valid/ready stream of activations, one element per beat in row-major vector order (row 0 first), and turns each SA_SIZE-element column vector into per-row writes for the skew buffer. It issues CMD_QUEUE for rows 0..SA_SIZE-2 and CMD_STREAM for row SA_SIZE-1. After the last vector of a tile it injects zero vectors so the skewed data drains fully into the array.

## Interface
- SA_SIZE, 8, array dimension; legal values are powers of two ≥ 2.
- ACTIVATION_SIZE, 32, activation width in bits.
- CNT_W, 16, width of the tile vector count.

- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begins a tile when idle.
- num_vectors  in  CNT_W  number of column vectors K in the tile; sampled on the accepted start.
- stall  in  1  array hold request; freezes sequencing while high.
- in_valid  in  1  activation beat valid.
- in_ready  out  1  activation beat accepted.
- in_data  in  ACTIVATION_SIZE  activation value.
- act_out  out  ACTIVATION_SIZE  value for the skew buffer.
- act_row_idx  out  $clog2(SA_SIZE)  target row.
- cmd  out  command_t  CMD_NOP, CMD_QUEUE or CMD_STREAM.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the tile, including flush, is complete.

## Operation
- States:
  - IDLE: waits for start.
  - LOAD: consumes K×SA_SIZE beats from the input stream.
  - FLUSH: emits SA_SIZE-1 zero vectors.
  - DONE: single cycle; raises done.
- Transitions:
  - IDLE→LOAD on start with num_vectors≠0.
  - IDLE→DONE on start with num_vectors=0. No commands are issued.
  - LOAD→FLUSH after the last beat of vector K-1.
  - FLUSH→DONE after the last element of zero vector SA_SIZE-2.
  - DONE→IDLE unconditionally.
- Counters:
  - row_cnt, $clog2(SA_SIZE) bits, wraps SA_SIZE-1→0 at the end of each vector.
  - vec_cnt, CNT_W bits, counts vectors in LOAD and zero vectors in FLUSH; cleared on each state entry.
- Command rule, for every emitted element: cmd=CMD_QUEUE if row_cnt<SA_SIZE-1, else CMD_STREAM. act_row_idx=row_cnt.
- LOAD:
  - in_ready = (state==LOAD) && !stall.
  - A transfer occurs on in_valid && in_ready. Only then does the block emit in_data and advance row_cnt.
  - A cycle with no transfer emits cmd=CMD_NOP.
- FLUSH: emits act_out=0 each cycle that stall is low; emits CMD_NOP while stall is high. in_ready is low.
- In IDLE, DONE and FLUSH, in_ready is low.
- start is ignored while busy.
- busy=1 in LOAD, FLUSH and DONE.
- Full element sequence per tile: K×SA_SIZE data elements, then (SA_SIZE-1)×SA_SIZE zero elements. This yields K+SA_SIZE-1 CMD_STREAM commands in total.

## Timing
- act_out, act_row_idx, cmd, done and busy are registered.
- An element accepted, or a flush element generated, in cycle t appears on the outputs in cycle t+1.
- in_ready is combinational from state and stall. There is no combinational path from in_valid to in_ready.
- stall high in cycle t forces cmd=CMD_NOP in cycle t+1. row_cnt, vec_cnt and state hold.
- Reset values: cmd=CMD_NOP, act_out=0, act_row_idx=0, busy=0, done=0, in_ready=0, state=IDLE, all counters 0.
- Reset asserted mid-tile aborts immediately. No done pulse is produced and no further commands are issued. Beats not yet accepted remain with the upstream source.
- start in the DONE cycle is ignored. A start in the following cycle, with state in IDLE, is accepted.
- Minimum tile latency, with in_valid always high and stall low: start accepted at cycle 0 → first element output at cycle 2 → done at cycle (K+SA_SIZE-1)×SA_SIZE+2.

## Test plan
- Reset: hold resetn=0 for 3 cycles with in_valid=1 and start=1 → all outputs hold reset values and in_ready=0 throughout.
- SA_SIZE=4, K=1, data 1,2,3,4 streamed back-to-back → outputs (Q,0,1),(Q,1,2),(Q,2,3),(S,3,4), then three zero vectors each Q0,Q1,Q2,S3. done at cycle 18, exactly 4 CMD_STREAM total.
- SA_SIZE=4, K=2, in_valid toggling 1,0,1,0,… → CMD_NOP on gap cycles. Element order and values are unchanged. 5 CMD_STREAM total.
- stall held high for 3 cycles mid-vector in LOAD, then again in FLUSH → in_ready=0 and cmd=CMD_NOP for those cycles. The sequence resumes at the same row_cnt with no element lost or duplicated.
- start with num_vectors=0 → busy for one cycle, done pulse, no QUEUE or STREAM commands. A second start during a K=3 tile → ignored, and the element count is still 3×SA_SIZE plus flush.
- resetn low for 1 cycle at row_cnt=2 of vector 1 → outputs return to reset values, no done pulse. A fresh start then runs a complete, correct tile.
